// File: rtl/pipe_ctrl_if.sv
// Stage-signal bundle between the Y86 pipeline datapath and pipe_ctrl.
// The master is the datapath side; the slave is the controller.
interface pipe_ctrl_if #(
  parameter int unsigned WORD_W = 32
);
  logic [3:0]        D_icode_i;
  logic [3:0]        d_srcA_i;
  logic [3:0]        d_srcB_i;
  logic [3:0]        E_icode_i;
  logic [3:0]        E_ifun_i;
  logic [3:0]        E_dstM_i;
  logic [WORD_W-1:0] E_valA_i;
  logic [WORD_W-1:0] E_valB_i;
  logic [WORD_W-1:0] e_valE_i;
  logic              e_Cnd_i;
  logic [3:0]        W_icode_i;

  logic              F_stall_o;
  logic              D_stall_o;
  logic              W_stall_o;
  logic              D_bubble_o;
  logic              E_bubble_o;
  logic              cc_zf_o;
  logic              cc_sf_o;
  logic              cc_of_o;
  logic              halted_o;
  logic [31:0]       stall_cnt_o;
  logic [31:0]       bubble_cnt_o;

  modport master (
    output D_icode_i, d_srcA_i, d_srcB_i, E_icode_i, E_ifun_i, E_dstM_i,
           E_valA_i, E_valB_i, e_valE_i, e_Cnd_i, W_icode_i,
    input  F_stall_o, D_stall_o, W_stall_o, D_bubble_o, E_bubble_o,
           cc_zf_o, cc_sf_o, cc_of_o, halted_o, stall_cnt_o, bubble_cnt_o
  );

  modport slave (
    input  D_icode_i, d_srcA_i, d_srcB_i, E_icode_i, E_ifun_i, E_dstM_i,
           E_valA_i, E_valB_i, e_valE_i, e_Cnd_i, W_icode_i,
    output F_stall_o, D_stall_o, W_stall_o, D_bubble_o, E_bubble_o,
           cc_zf_o, cc_sf_o, cc_of_o, halted_o, stall_cnt_o, bubble_cnt_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Y86 pipeline control: condition codes, load/use, mispredict, ret wait, sticky halt.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
  parameter int unsigned WORD_W   = 32,
  parameter int unsigned RET_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  pipe_ctrl_if.slave  pif
);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_MRMOVL = 4'h5;
  localparam logic [3:0] I_OPL    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPL   = 4'hB;
  localparam logic [3:0] R_NONE   = 4'hF;

  localparam logic [3:0] F_ADD = 4'h0;
  localparam logic [3:0] F_SUB = 4'h1;

  localparam int unsigned MSB = WORD_W - 1;

  typedef enum logic {
    RUN,
    HALTED
  } state_t;

  state_t     st, st_nxt;
  logic [1:0] ret_cnt, ret_cnt_nxt;
  logic       zf, sf, of;
  logic       zf_nxt, sf_nxt, of_nxt;

  logic lu, mp, ret_start, ret_act;
  logic f_stall, d_stall, w_stall, d_bubble, e_bubble, halted;

  always_comb begin
    lu = ((pif.E_icode_i == I_MRMOVL) || (pif.E_icode_i == I_POPL)) &&
         (pif.E_dstM_i != R_NONE) &&
         ((pif.E_dstM_i == pif.d_srcA_i) || (pif.E_dstM_i == pif.d_srcB_i));
    mp        = (pif.E_icode_i == I_JXX) && !pif.e_Cnd_i;
    ret_start = (pif.D_icode_i == I_RET) && !lu && !mp;
    ret_act   = ret_start || (ret_cnt != 2'd0);
  end

  always_comb begin
    st_nxt      = st;
    ret_cnt_nxt = ret_cnt;
    zf_nxt      = zf;
    sf_nxt      = sf;
    of_nxt      = of;
    f_stall     = 1'b0;
    d_stall     = 1'b0;
    w_stall     = 1'b0;
    d_bubble    = 1'b0;
    e_bubble    = 1'b0;
    halted      = 1'b0;

    case (st)
      HALTED: begin
        f_stall = 1'b1;
        d_stall = 1'b1;
        w_stall = 1'b1;
        halted  = 1'b1;
      end
      default: begin
        if (pif.W_icode_i == I_HALT)
          st_nxt = HALTED;

        if (pif.E_icode_i == I_OPL) begin
          zf_nxt = (pif.e_valE_i == '0);
          sf_nxt = pif.e_valE_i[MSB];
          case (pif.E_ifun_i)
            F_ADD:   of_nxt = (pif.E_valA_i[MSB] == pif.E_valB_i[MSB]) &&
                              (pif.e_valE_i[MSB] != pif.E_valA_i[MSB]);
            F_SUB:   of_nxt = (pif.E_valA_i[MSB] != pif.E_valB_i[MSB]) &&
                              (pif.e_valE_i[MSB] != pif.E_valB_i[MSB]);
            default: of_nxt = 1'b0;
          endcase
        end

        // A held or squashed ret must not arm the wait; it re-presents later.
        if (ret_start)
          ret_cnt_nxt = 2'(RET_WAIT);
        else if (ret_cnt != 2'd0)
          ret_cnt_nxt = ret_cnt - 2'd1;

        if (lu) begin
          f_stall  = 1'b1;
          d_stall  = 1'b1;
          e_bubble = 1'b1;
        end else if (mp) begin
          d_bubble = 1'b1;
          e_bubble = 1'b1;
        end else if (ret_act) begin
          f_stall  = 1'b1;
          d_bubble = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st      <= RUN;
      ret_cnt <= 2'd0;
      zf      <= 1'b1;
      sf      <= 1'b0;
      of      <= 1'b0;
    end else begin
      st      <= st_nxt;
      ret_cnt <= ret_cnt_nxt;
      zf      <= zf_nxt;
      sf      <= sf_nxt;
      of      <= of_nxt;
    end
  end

  // Control outputs are forced low for the whole time reset is held.
  assign pif.F_stall_o  = rst & f_stall;
  assign pif.D_stall_o  = rst & d_stall;
  assign pif.W_stall_o  = rst & w_stall;
  assign pif.D_bubble_o = rst & d_bubble;
  assign pif.E_bubble_o = rst & e_bubble;
  assign pif.halted_o   = rst & halted;
  assign pif.cc_zf_o    = zf;
  assign pif.cc_sf_o    = sf;
  assign pif.cc_of_o    = of;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt, bubble_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (st == RUN) begin
      if (f_stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
      if ((d_bubble || e_bubble) && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

  assign pif.stall_cnt_o  = stall_cnt;
  assign pif.bubble_cnt_o = bubble_cnt;
`else
  assign pif.stall_cnt_o  = '0;
  assign pif.bubble_cnt_o = '0;
`endif

  logic unused_bits;
  assign unused_bits = ^{pif.E_valA_i, pif.E_valB_i};

endmodule
